// File: rtl/quad_filter_decoder.sv
// Rotary encoder front end: per-channel synchroniser and debounce,
// followed by a registered quadrature decoder with step and error pulses.
module quad_filter_decoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic       cw,
    output logic       ccw,
    output logic       err,
    output logic [1:0] state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 1 is A, index 0 is B, so r_f reads directly as {a,b}.
    logic [1:0][SYNC_STAGES-1:0] r_sync;
    logic [1:0][CNT_W-1:0]       r_cnt;
    logic [1:0]                  r_f;
    logic [1:0]                  r_prev;
    logic                        r_cw;
    logic                        r_ccw;
    logic                        r_err;

    logic [1:0] w_raw;
    logic [1:0] w_s;
    logic       w_cw;
    logic       w_ccw;
    logic       w_err;

    assign w_raw = {a, b};
    assign w_s   = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_f    <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (w_s[i] == r_f[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_f[i]   <= w_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_cw  = 1'b0;
        w_ccw = 1'b0;
        w_err = 1'b0;
        case ({r_prev, r_f})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_cw  = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_ccw = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: w_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 2'b11;
            r_cw   <= 1'b0;
            r_ccw  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_prev <= r_f;
            r_cw   <= w_cw;
            r_ccw  <= w_ccw;
            r_err  <= w_err;
        end
    end

    assign cw    = r_cw;
    assign ccw   = r_ccw;
    assign err   = r_err;
    assign state = r_f;

endmodule

// File: tb/tb_quad_filter_decoder.sv
// Bench for quad_filter_decoder: directed scenarios plus random pin
// activity, all checked against a Gray-position reference model.
module tb_quad_filter_decoder;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       b;
    logic       cw;
    logic       ccw;
    logic       err;
    logic [1:0] state;

    always #5 clk = ~clk;

    quad_filter_decoder #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .cw   (cw),
        .ccw  (ccw),
        .err  (err),
        .state(state)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_cw;
    int n_ccw;
    int n_err;
    int tick_no;
    int first_pulse;

    // Reference model state
    logic       q_a[$];
    logic       q_b[$];
    logic       h_a[$];
    logic       h_b[$];
    logic       m_fa;
    logic       m_fb;
    logic [1:0] m_prev;
    logic       m_cw;
    logic       m_ccw;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Position of a state along the clockwise walk 11->10->00->01
    function automatic int gpos(input logic [1:0] s);
        case (s)
            2'b11:   return 0;
            2'b10:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit all_eq(input logic q[$], input logic v);
        if (q.size() < DEB) return 1'b0;
        foreach (q[i]) if (q[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        h_a.delete();
        h_b.delete();
        for (int i = 0; i < SYNC; i++) begin
            q_a.push_back(1'b1);
            q_b.push_back(1'b1);
        end
        m_fa   = 1'b1;
        m_fb   = 1'b1;
        m_prev = 2'b11;
        m_cw   = 1'b0;
        m_ccw  = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock edge of the reference, using pre-edge values throughout
    task automatic model_edge(input logic ra, input logic rb);
        logic       sa;
        logic       sb;
        logic [1:0] cur;
        int         d;
        sa  = q_a[0];
        sb  = q_b[0];
        cur = {m_fa, m_fb};
        d   = (gpos(cur) - gpos(m_prev) + 4) % 4;
        m_cw   = (d == 1);
        m_ccw  = (d == 3);
        m_err  = (d == 2);
        m_prev = cur;
        h_a.push_back(sa);
        if (h_a.size() > DEB) void'(h_a.pop_front());
        if (all_eq(h_a, !m_fa)) begin
            m_fa = !m_fa;
            h_a.delete();
        end
        h_b.push_back(sb);
        if (h_b.size() > DEB) void'(h_b.pop_front());
        if (all_eq(h_b, !m_fb)) begin
            m_fb = !m_fb;
            h_b.delete();
        end
        void'(q_a.pop_front());
        void'(q_b.pop_front());
        q_a.push_back(ra);
        q_b.push_back(rb);
    endtask

    task automatic clear_counts();
        n_cw        = 0;
        n_ccw       = 0;
        n_err       = 0;
        tick_no     = 0;
        first_pulse = -1;
    endtask

    // Called at a falling edge: drive pins, step one clock, check.
    task automatic tick(input logic na, input logic nb);
        a = na;
        b = nb;
        @(posedge clk);
        model_edge(na, nb);
        @(negedge clk);
        tick_no++;
        chk("outs", {27'd0, cw, ccw, err, state},
            {27'd0, m_cw, m_ccw, m_err, m_fa, m_fb});
        if (cw)  n_cw++;
        if (ccw) n_ccw++;
        if (err) n_err++;
        if ((cw || ccw) && first_pulse < 0) first_pulse = tick_no;
    endtask

    task automatic hold(input logic na, input logic nb, input int n);
        repeat (n) tick(na, nb);
    endtask

    initial begin
        reset = 1'b1;
        a     = 1'b1;
        b     = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outs", {27'd0, cw, ccw, err, state}, 32'h3);
        reset = 1'b0;

        clear_counts();
        hold(1, 1, 50);
        chk("idle_pulses", n_cw + n_ccw + n_err, 0);

        clear_counts();
        hold(1, 0, 20);
        hold(0, 0, 20);
        hold(0, 1, 20);
        hold(1, 1, 20);
        chk("cw_cycle_cw", n_cw, 4);
        chk("cw_cycle_ccw", n_ccw, 0);
        chk("cw_latency", first_pulse, SYNC + DEB + 1);

        clear_counts();
        hold(0, 1, 20);
        hold(0, 0, 20);
        hold(1, 0, 20);
        hold(1, 1, 20);
        chk("ccw_cycle_ccw", n_ccw, 4);
        chk("ccw_cycle_cw", n_cw, 0);

        clear_counts();
        hold(1, 0, 20);
        hold(0, 0, 20);
        chk("rev_cw", n_cw, 2);
        hold(1, 0, 20);
        hold(1, 1, 20);
        chk("rev_ccw", n_ccw, 2);
        chk("rev_state", {30'd0, state}, 32'h3);

        clear_counts();
        hold(0, 1, 3);
        hold(1, 1, 2);
        hold(0, 1, 3);
        hold(0, 1, 20);
        chk("bounce_pulses", n_cw + n_ccw + n_err, 1);
        chk("bounce_ccw", n_ccw, 1);
        chk("bounce_latency", first_pulse, 6 + SYNC + DEB);
        hold(1, 1, 20);

        clear_counts();
        hold(0, 0, 20);
        chk("double_err", n_err, 1);
        chk("double_steps", n_cw + n_ccw, 0);
        chk("double_state", {30'd0, state}, 32'h0);
        hold(1, 1, 20);

        clear_counts();
        hold(0, 1, 2);
        reset = 1'b1;
        #1;
        chk("midrst_outs", {27'd0, cw, ccw, err, state}, 32'h3);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_counts();
        hold(0, 1, 20);
        chk("postrst_ccw", n_ccw, 1);
        chk("postrst_cw", n_cw + n_err, 0);
        chk("postrst_latency", first_pulse, SYNC + DEB + 1);
        hold(1, 1, 20);

        clear_counts();
        repeat (60) begin
            logic ra;
            logic rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            hold(ra, rb, $urandom_range(1, 10));
        end
        hold(1, 1, 20);
        chk("rand_state", {30'd0, state}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
